// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/bubble controller for the 5-stage pipeline.
// Decodes hazards and busy signals into per-register stall/bubble controls,
// sequences multi-cycle HI/LO operations held in E, and kills the wrong-path
// fetch for one cycle after an exception or ERET commit.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  d_src1,
    input  logic [4:0]  d_src2,
    input  logic [4:0]  e_dst,
    input  logic [4:0]  m_dst,
    input  logic        e_isLoad,
    input  logic        m_isLoad,
    input  logic        md_start,
    input  logic        md_isDiv,
    input  logic        ibus_busy,
    input  logic        dbus_busy,
    input  logic        exception,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_stall,
    output logic        E_bubble,
    output logic        M_stall,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        W_bubble,
    output logic        md_busy,
    output logic        md_done,
    output logic        md_abort,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MD    = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Counter preload is total occupancy minus the issue cycle.
    localparam logic [5:0] L_MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] L_DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_md_done;
    logic        r_md_abort;
    logic        r_md_skip;      // the just-finished op is still in E; ignore its md_start
    logic [31:0] r_stall_cycles;

    logic        w_lu;
    logic [5:0]  w_md_load;
    logic        w_md_req;
    logic        w_issue;

    // Hazard detection and multi-cycle issue qualification.
    always_comb begin
        w_lu = 1'b0;
        if (e_isLoad == 1'b1) begin
            if ((d_src1 != 5'd0) && (d_src1 == e_dst)) begin
                w_lu = 1'b1;
            end else if ((d_src2 != 5'd0) && (d_src2 == e_dst)) begin
                w_lu = 1'b1;
            end else begin
                w_lu = w_lu;
            end
        end else begin
            w_lu = w_lu;
        end
        if (m_isLoad == 1'b1) begin
            if ((d_src1 != 5'd0) && (d_src1 == m_dst)) begin
                w_lu = 1'b1;
            end else if ((d_src2 != 5'd0) && (d_src2 == m_dst)) begin
                w_lu = 1'b1;
            end else begin
                w_lu = w_lu;
            end
        end else begin
            w_lu = w_lu;
        end
        w_md_load = md_isDiv ? L_DIV_LOAD : L_MUL_LOAD;
        // RUN and FLUSH both accept a new HI/LO op.
        w_md_req  = (r_state != ST_MD) && md_start && !r_md_skip;
        w_issue   = w_md_req && (w_md_load != 6'd0);
    end

    // Prioritised stall/bubble decode, valid in the same cycle.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_stall  = 1'b0;
        E_bubble = 1'b0;
        M_stall  = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        if ((resetn == 1'b0) || (exception == 1'b1)) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_bubble = 1'b1;
        end else begin
            if (dbus_busy == 1'b1) begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_stall  = 1'b1;
                M_stall  = 1'b1;
                W_bubble = 1'b1;
            end else if ((r_state == ST_MD) || (w_issue == 1'b1)) begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_stall  = 1'b1;
                M_bubble = 1'b1;
            end else if (w_lu == 1'b1) begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
            end else if (ibus_busy == 1'b1) begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
            end else begin
                F_stall  = 1'b0;
            end
            // The instruction fetched on the wrong path is discarded.
            if (r_state == ST_FLUSH) begin
                D_stall  = 1'b0;
                D_bubble = 1'b1;
            end else begin
                D_stall  = D_stall;
            end
        end
    end

    // FSM, MD counter, completion/abort pulses and stall statistics.
    always_ff @(posedge clk) begin
        if (resetn == 1'b0) begin
            r_state        <= ST_RUN;
            r_cnt          <= 6'd0;
            r_md_done      <= 1'b0;
            r_md_abort     <= 1'b0;
            r_md_skip      <= 1'b0;
            r_stall_cycles <= 32'd0;
        end else begin
            r_md_done  <= 1'b0;
            r_md_abort <= 1'b0;
            if (F_stall == 1'b1) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (exception == 1'b1) begin
                r_md_abort <= (r_state == ST_MD);
                r_state    <= ST_FLUSH;
                r_cnt      <= 6'd0;
                r_md_skip  <= 1'b0;
            end else if (dbus_busy == 1'b1) begin
                // Counter and skip flag freeze; FLUSH never outlives one cycle.
                if (r_state == ST_FLUSH) begin
                    r_state <= ST_RUN;
                end else begin
                    r_state <= r_state;
                end
            end else begin
                case (r_state)
                    ST_MD: begin
                        if (r_cnt <= 6'd1) begin
                            r_md_done <= 1'b1;
                            r_state   <= ST_RUN;
                            r_cnt     <= 6'd0;
                            r_md_skip <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                    ST_RUN, ST_FLUSH: begin
                        r_md_skip <= 1'b0;
                        if (w_issue == 1'b1) begin
                            r_state <= ST_MD;
                            r_cnt   <= w_md_load;
                        end else if (w_md_req == 1'b1) begin
                            // Single-cycle op: completes without stalling.
                            r_md_done <= 1'b1;
                            r_state   <= ST_RUN;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state   <= ST_RUN;
                        r_cnt     <= 6'd0;
                        r_md_skip <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign md_busy      = (r_state == ST_MD);
    assign md_done      = r_md_done;
    assign md_abort     = r_md_abort;
    assign ctrl_state   = r_state;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table of single-cycle hazard
// vectors plus hand-written multi-cycle sequences, checked via a scoreboard.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  d_src1, d_src2, e_dst, m_dst;
    logic        e_isLoad, m_isLoad, md_start, md_isDiv;
    logic        ibus_busy, dbus_busy, exception;
    logic        F_stall, D_stall, D_bubble, E_stall, E_bubble;
    logic        M_stall, M_bubble, W_stall, W_bubble;
    logic        md_busy, md_done, md_abort;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles;

    pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .resetn(resetn),
        .d_src1(d_src1), .d_src2(d_src2), .e_dst(e_dst), .m_dst(m_dst),
        .e_isLoad(e_isLoad), .m_isLoad(m_isLoad),
        .md_start(md_start), .md_isDiv(md_isDiv),
        .ibus_busy(ibus_busy), .dbus_busy(dbus_busy), .exception(exception),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .md_busy(md_busy), .md_done(md_done), .md_abort(md_abort),
        .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Stall/bubble patterns: {F_stall, D_stall, D_bubble, E_stall, E_bubble,
    //                         M_stall, M_bubble, W_stall, W_bubble}
    localparam logic [8:0] P_NONE  = 9'b000000000;
    localparam logic [8:0] P_BUB   = 9'b001010101;
    localparam logic [8:0] P_DBUS  = 9'b110101001;
    localparam logic [8:0] P_MD    = 9'b110100100;
    localparam logic [8:0] P_LU    = 9'b110010000;
    localparam logic [8:0] P_IB    = 9'b101000000;
    localparam logic [8:0] P_FL    = 9'b001000000;
    localparam logic [8:0] P_FL_LU = 9'b101010000;
    localparam logic [1:0] S_RUN = 2'd0, S_MD = 2'd1, S_FL = 2'd2;

    typedef struct {
        string      name;
        logic [13:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [4:0] s1, s2, ed, md;
        logic       el, ml, ib, db;
        logic [8:0] exp;
    } vec_t;
    vec_t tbl[12];

    int    n_checks = 0;
    int    n_fail   = 0;
    int    m_stalls = 0;
    int    base;

    function automatic logic [13:0] ex(logic [8:0] p, logic busy, logic done,
                                       logic abort, logic [1:0] st);
        return {p, busy, done, abort, st};
    endfunction

    function automatic vec_t mkv(logic [4:0] s1, logic [4:0] s2, logic [4:0] ed,
                                 logic [4:0] md, logic el, logic ml, logic ib,
                                 logic db, logic [8:0] exp);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.ed = ed; v.md = md;
        v.el = el; v.ml = ml; v.ib = ib; v.db = db; v.exp = exp;
        return v;
    endfunction

    task automatic clear_inputs();
        d_src1 = 5'd0; d_src2 = 5'd0; e_dst = 5'd0; m_dst = 5'd0;
        e_isLoad = 1'b0; m_isLoad = 1'b0; md_start = 1'b0; md_isDiv = 1'b0;
        ibus_busy = 1'b0; dbus_busy = 1'b0; exception = 1'b0;
    endtask

    // One cycle: push expectation, sample at negedge, pop and compare.
    task automatic step(string name, logic [13:0] exp);
        sb_t e;
        logic [13:0] obs;
        sb_q.push_back('{name, exp});
        @(negedge clk);
        obs = {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble,
               W_stall, W_bubble, md_busy, md_done, md_abort, ctrl_state};
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
        end
        n_checks++;
        if (stall_cycles !== 32'(m_stalls)) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles, m_stalls);
        end
        if (resetn == 1'b0) m_stalls = 0;
        else if (e.exp[13]) m_stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(string name, int exp);
        @(negedge clk);
        n_checks++;
        if (stall_cycles !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, stall_cycles, exp);
        end
        @(posedge clk);
        #1;
        m_stalls = exp;
    endtask

    initial begin
        tbl[0]  = mkv(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE);
        tbl[1]  = mkv(5'd5, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, P_LU);
        tbl[2]  = mkv(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, P_NONE);
        tbl[3]  = mkv(5'd1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, P_LU);
        tbl[4]  = mkv(5'd7, 5'd2, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE);
        tbl[5]  = mkv(5'd4, 5'd8, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE);
        tbl[6]  = mkv(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, P_IB);
        tbl[7]  = mkv(5'd6, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, P_DBUS);
        tbl[8]  = mkv(5'd6, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, P_LU);
        tbl[9]  = mkv(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, P_DBUS);
        tbl[10] = mkv(5'd0, 5'd31, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, P_LU);
        tbl[11] = mkv(5'd3, 5'd0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, P_IB);

        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("reset", ex(P_BUB, 1'b0, 1'b0, 1'b0, S_RUN));
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            d_src1 = tbl[i].s1; d_src2 = tbl[i].s2;
            e_dst = tbl[i].ed; m_dst = tbl[i].md;
            e_isLoad = tbl[i].el; m_isLoad = tbl[i].ml;
            ibus_busy = tbl[i].ib; dbus_busy = tbl[i].db;
            step($sformatf("vec%0d", i), ex(tbl[i].exp, 1'b0, 1'b0, 1'b0, S_RUN));
        end
        clear_inputs();

        // Full divide: 32 cycles of stall, one md_done.
        base = m_stalls;
        md_start = 1'b1; md_isDiv = 1'b1;
        step("div_issue", ex(P_MD, 1'b0, 1'b0, 1'b0, S_RUN));
        for (int i = 0; i < 31; i++) step("div_md", ex(P_MD, 1'b1, 1'b0, 1'b0, S_MD));
        step("div_done", ex(P_NONE, 1'b0, 1'b1, 1'b0, S_RUN));
        md_start = 1'b0;
        step("div_after", ex(P_NONE, 1'b0, 1'b0, 1'b0, S_RUN));
        check_count("div_stall_cycles", base + 32);

        // Multiply: 4 cycles total.
        md_start = 1'b1; md_isDiv = 1'b0;
        step("mul_issue", ex(P_MD, 1'b0, 1'b0, 1'b0, S_RUN));
        for (int i = 0; i < 3; i++) step("mul_md", ex(P_MD, 1'b1, 1'b0, 1'b0, S_MD));
        step("mul_done", ex(P_NONE, 1'b0, 1'b1, 1'b0, S_RUN));
        md_start = 1'b0;

        // dbus_busy for 3 cycles during a divide extends MD by 3.
        md_start = 1'b1; md_isDiv = 1'b1;
        step("dbd_issue", ex(P_MD, 1'b0, 1'b0, 1'b0, S_RUN));
        for (int i = 0; i < 5; i++) step("dbd_md_a", ex(P_MD, 1'b1, 1'b0, 1'b0, S_MD));
        dbus_busy = 1'b1;
        for (int i = 0; i < 3; i++) step("dbd_dbus", ex(P_DBUS, 1'b1, 1'b0, 1'b0, S_MD));
        dbus_busy = 1'b0;
        for (int i = 0; i < 26; i++) step("dbd_md_b", ex(P_MD, 1'b1, 1'b0, 1'b0, S_MD));
        step("dbd_done", ex(P_NONE, 1'b0, 1'b1, 1'b0, S_RUN));
        md_start = 1'b0;

        // Exception in the 10th cycle of a divide.
        md_start = 1'b1; md_isDiv = 1'b1;
        step("exc_issue", ex(P_MD, 1'b0, 1'b0, 1'b0, S_RUN));
        for (int i = 0; i < 8; i++) step("exc_md", ex(P_MD, 1'b1, 1'b0, 1'b0, S_MD));
        exception = 1'b1;
        step("exc_hit", ex(P_BUB, 1'b1, 1'b0, 1'b0, S_MD));
        exception = 1'b0; md_start = 1'b0;
        step("exc_flush", ex(P_FL, 1'b0, 1'b0, 1'b1, S_FL));
        step("exc_run", ex(P_NONE, 1'b0, 1'b0, 1'b0, S_RUN));

        // Exception during FLUSH restarts FLUSH; FLUSH overrides a D stall.
        exception = 1'b1;
        step("exc2_hit", ex(P_BUB, 1'b0, 1'b0, 1'b0, S_RUN));
        step("exc2_again", ex(P_BUB, 1'b0, 1'b0, 1'b0, S_FL));
        exception = 1'b0;
        d_src1 = 5'd5; e_dst = 5'd5; e_isLoad = 1'b1;
        step("flush_lu", ex(P_FL_LU, 1'b0, 1'b0, 1'b0, S_FL));
        step("run_lu", ex(P_LU, 1'b0, 1'b0, 1'b0, S_RUN));
        clear_inputs();

        // Reset in the middle of a divide.
        md_start = 1'b1; md_isDiv = 1'b1;
        step("rst_issue", ex(P_MD, 1'b0, 1'b0, 1'b0, S_RUN));
        for (int i = 0; i < 4; i++) step("rst_md", ex(P_MD, 1'b1, 1'b0, 1'b0, S_MD));
        resetn = 1'b0;
        step("rst_hold", ex(P_BUB, 1'b1, 1'b0, 1'b0, S_MD));
        resetn = 1'b1; md_start = 1'b0;
        step("rst_after", ex(P_NONE, 1'b0, 1'b0, 1'b0, S_RUN));
        step("rst_after2", ex(P_NONE, 1'b0, 1'b0, 1'b0, S_RUN));
        check_count("rst_stall_cycles", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
